barrier_scheduler: RTL and testbench

Pool controller that shares NUM_SLOTS hardware barrier slots among NUM_CORES cores. A host allocates a slot with a participant mask. Cores post arrivals against a slot ID. When every participant has arrived, the block pulses a release to exactly those cores and re-arms the slot for its next generation. It sits between the core sequencers and the per-core barrier wait/release lines, replacing hard-wired single-barrier use.

---
 rtl/barrier_pkg.sv | 33 +++
 rtl/barrier_slot.sv | 97 +++++++++
 rtl/barrier_scheduler.sv | 92 +++++++++
 tb/tb_barrier_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrier_pkg.sv
// Shared types for the barrier scheduler.
// Provides the per-slot FSM state encoding, the config opcode, the slot record
// used as a debug view of each slot, and the slot-ID width helper.
package barrier_pkg;

   localparam int MAX_CORES = 16;
   localparam int GEN_W     = 4;

   typedef enum logic [1:0] {
      SLOT_FREE    = 2'd0,
      SLOT_ARMED   = 2'd1,
      SLOT_RELEASE = 2'd2
   } slot_state_e;

   typedef enum logic {
      CFG_ALLOC = 1'b0,
      CFG_FREE  = 1'b1
   } cfg_op_e;

   // Mask/arrived are sized for the largest supported core count; bits at and
   // above NUM_CORES are held at zero.
   typedef struct packed {
      slot_state_e            state;
      logic [MAX_CORES-1:0]   mask;
      logic [MAX_CORES-1:0]   arrived;
      logic [GEN_W-1:0]       gen;
   } slot_t;

   function automatic int slot_w(input int num_slots);
      return (num_slots > 1) ? $clog2(num_slots) : 1;
   endfunction

endpackage

// File: rtl/barrier_slot.sv
// One barrier slot: FSM (FREE/ARMED/RELEASE) plus mask, arrived and generation
// registers.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   cmd_valid      config command addressed to this slot
//   cmd_op         ALLOC or FREE
//   cmd_mask       participant mask for ALLOC
//   arrive         per-core arrival strobes already decoded for this slot
//   cmd_ok         combinational accept result for the current command
//   rel_mask       cores released this cycle (mask while in RELEASE)
//   busy           slot is allocated
//   gen            completed-generation counter
//   arrive_err     at least one arrival this cycle was illegal
//   dbg            full slot record (state and registers)
module barrier_slot
   import barrier_pkg::*;
#(
   parameter int NUM_CORES = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_valid,
   input  cfg_op_e              cmd_op,
   input  logic [NUM_CORES-1:0] cmd_mask,
   input  logic [NUM_CORES-1:0] arrive,
   output logic                 cmd_ok,
   output logic [NUM_CORES-1:0] rel_mask,
   output logic                 busy,
   output logic [GEN_W-1:0]     gen,
   output logic                 arrive_err,
   output slot_t                dbg
);

   slot_t q, d;
   logic [NUM_CORES-1:0] mask, arrived, legal, acc;
   logic                 free_go;

   assign mask    = q.mask[NUM_CORES-1:0];
   assign arrived = q.arrived[NUM_CORES-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= '0;
      else          q <= d;
   end

   always_comb begin
      d       = q;
      cmd_ok  = 1'b0;
      legal   = '0;
      free_go = 1'b0;
      if (cmd_valid) begin
         if (cmd_op == CFG_ALLOC) cmd_ok = (q.state == SLOT_FREE) && (cmd_mask != '0);
         else                     cmd_ok = (q.state == SLOT_ARMED) && (arrived == '0);
      end
      free_go = cmd_ok && (cmd_op == CFG_FREE);
      // A slot being freed this edge accepts no arrivals; RELEASE cycles do,
      // and those count toward the next generation.
      if ((q.state != SLOT_FREE) && !free_go) legal = arrive & mask & ~arrived;
      acc = arrived | legal;
      case (q.state)
         SLOT_FREE: begin
            if (cmd_ok) begin
               d.state                  = SLOT_ARMED;
               d.mask                   = '0;
               d.mask[NUM_CORES-1:0]    = cmd_mask;
               d.arrived                = '0;
               d.gen                    = '0;
            end
         end
         SLOT_ARMED: begin
            if (free_go) begin
               d.state   = SLOT_FREE;
               d.mask    = '0;
               d.arrived = '0;
            end else if (acc == mask) begin
               d.state   = SLOT_RELEASE;
               d.arrived = '0;
               d.gen     = q.gen + 1'b1;
            end else begin
               d.arrived[NUM_CORES-1:0] = acc;
            end
         end
         SLOT_RELEASE: begin
            d.state                  = SLOT_ARMED;
            d.arrived[NUM_CORES-1:0] = acc;
         end
         default: d = '0;
      endcase
   end

   assign arrive_err = |(arrive & ~legal);
   assign rel_mask   = (q.state == SLOT_RELEASE) ? mask : '0;
   assign busy       = (q.state != SLOT_FREE);
   assign gen        = q.gen;
   assign dbg        = q;

endmodule

// File: rtl/barrier_scheduler.sv
// Pool of NUM_SLOTS barrier slots shared among NUM_CORES cores.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_cfg_valid/op/slot/mask  host ALLOC/FREE command (always accepted)
//   out_cfg_done/ok     registered command completion and result
//   in_arrive, in_arrive_slot  per-core arrival strobe and target slot
//   out_release         per-core release pulse (OR over all slots)
//   out_slot_busy       per-slot allocated flag
//   out_generation      per-slot 4-bit generation counter
//   out_error, in_error_clear  sticky illegal-arrival flag and its clear
//   dbg_slots           per-slot state/register record, slot s at s*$bits(slot_t)
module barrier_scheduler
   import barrier_pkg::*;
#(
   parameter  int NUM_CORES = 4,
   parameter  int NUM_SLOTS = 4,
   localparam int SLOT_W    = slot_w(NUM_SLOTS),
   localparam int SLOT_BITS = $bits(slot_t)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           in_cfg_valid,
   input  logic                           in_cfg_op,
   input  logic [SLOT_W-1:0]              in_cfg_slot,
   input  logic [NUM_CORES-1:0]           in_cfg_mask,
   output logic                           out_cfg_done,
   output logic                           out_cfg_ok,
   input  logic [NUM_CORES-1:0]           in_arrive,
   input  logic [NUM_CORES*SLOT_W-1:0]    in_arrive_slot,
   output logic [NUM_CORES-1:0]           out_release,
   output logic [NUM_SLOTS-1:0]           out_slot_busy,
   output logic [NUM_SLOTS*GEN_W-1:0]     out_generation,
   output logic                           out_error,
   input  logic                           in_error_clear,
   output logic [NUM_SLOTS*SLOT_BITS-1:0] dbg_slots
);

   logic [NUM_SLOTS-1:0] slot_ok;
   logic [NUM_SLOTS-1:0] slot_err;
   logic [NUM_CORES-1:0] slot_rel [NUM_SLOTS];

   for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      logic [NUM_CORES-1:0] arr;
      logic                 cmd;
      slot_t                dbg;

      always_comb begin
         arr = '0;
         for (int c = 0; c < NUM_CORES; c++)
            arr[c] = in_arrive[c] && (in_arrive_slot[c*SLOT_W +: SLOT_W] == SLOT_W'(s));
      end

      assign cmd = in_cfg_valid && (in_cfg_slot == SLOT_W'(s));

      barrier_slot #(.NUM_CORES(NUM_CORES)) u_slot (
         .clk        (clk),
         .reset_n    (reset_n),
         .cmd_valid  (cmd),
         .cmd_op     (cfg_op_e'(in_cfg_op)),
         .cmd_mask   (in_cfg_mask),
         .arrive     (arr),
         .cmd_ok     (slot_ok[s]),
         .rel_mask   (slot_rel[s]),
         .busy       (out_slot_busy[s]),
         .gen        (out_generation[s*GEN_W +: GEN_W]),
         .arrive_err (slot_err[s]),
         .dbg        (dbg)
      );

      assign dbg_slots[s*SLOT_BITS +: SLOT_BITS] = dbg;
   end

   always_comb begin
      out_release = '0;
      for (int s = 0; s < NUM_SLOTS; s++) out_release = out_release | slot_rel[s];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_cfg_done <= 1'b0;
         out_cfg_ok   <= 1'b0;
         out_error    <= 1'b0;
      end else begin
         out_cfg_done <= in_cfg_valid;
         // Only the addressed slot can report ok, so the OR is the result.
         out_cfg_ok   <= in_cfg_valid && (|slot_ok);
         if (|slot_err)           out_error <= 1'b1;
         else if (in_error_clear) out_error <= 1'b0;
      end
   end

endmodule

// File: tb/tb_barrier_scheduler.sv
module tb_barrier_scheduler;
   import barrier_pkg::*;

   localparam int NC = 4;
   localparam int NS = 4;
   localparam int SB = $bits(slot_t);

   logic            clk = 1'b0;
   logic            reset_n;
   logic            in_cfg_valid, in_cfg_op;
   logic [1:0]      in_cfg_slot;
   logic [NC-1:0]   in_cfg_mask;
   logic            out_cfg_done, out_cfg_ok;
   logic [NC-1:0]   in_arrive;
   logic [NC*2-1:0] in_arrive_slot;
   logic [NC-1:0]   out_release;
   logic [NS-1:0]   out_slot_busy;
   logic [NS*4-1:0] out_generation;
   logic            out_error, in_error_clear;
   logic [NS*SB-1:0] dbg_slots;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: allocation flag, release-in-progress flag, mask, arrived set, generation
   bit         m_alloc [NS];
   bit         m_rel   [NS];
   logic [3:0] m_mask  [NS];
   logic [3:0] m_arr   [NS];
   logic [3:0] m_gen   [NS];
   logic            exp_done, exp_ok, exp_error;
   logic [NC-1:0]   exp_release;
   logic [NS-1:0]   exp_busy;
   logic [NS*4-1:0] exp_gen;

   barrier_scheduler #(.NUM_CORES(NC), .NUM_SLOTS(NS)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_cfg_valid   (in_cfg_valid),
      .in_cfg_op      (in_cfg_op),
      .in_cfg_slot    (in_cfg_slot),
      .in_cfg_mask    (in_cfg_mask),
      .out_cfg_done   (out_cfg_done),
      .out_cfg_ok     (out_cfg_ok),
      .in_arrive      (in_arrive),
      .in_arrive_slot (in_arrive_slot),
      .out_release    (out_release),
      .out_slot_busy  (out_slot_busy),
      .out_generation (out_generation),
      .out_error      (out_error),
      .in_error_clear (in_error_clear),
      .dbg_slots      (dbg_slots)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int s = 0; s < NS; s++) begin
         m_alloc[s] = 0; m_rel[s] = 0; m_mask[s] = '0; m_arr[s] = '0; m_gen[s] = '0;
      end
      exp_done = 0; exp_ok = 0; exp_error = 0; exp_release = '0; exp_busy = '0; exp_gen = '0;
   endtask

   // Advances the model by one clock edge using the inputs presented at that edge.
   task automatic model_step();
      logic [3:0] newarr [NS];
      logic ok, err, freeing;
      int ts, s;
      ts = int'(in_cfg_slot); ok = 0; err = 0;
      for (int i = 0; i < NS; i++) newarr[i] = '0;
      if (in_cfg_valid) begin
         if (in_cfg_op == 1'b0) ok = !m_alloc[ts] && (in_cfg_mask != 4'b0);
         else                   ok = m_alloc[ts] && !m_rel[ts] && (m_arr[ts] == 4'b0);
      end
      for (int c = 0; c < NC; c++) begin
         if (in_arrive[c]) begin
            s = int'(in_arrive_slot[c*2 +: 2]);
            freeing = ok && in_cfg_op && (ts == s);
            if (m_alloc[s] && !freeing && m_mask[s][c] && !m_arr[s][c]) newarr[s][c] = 1'b1;
            else err = 1'b1;
         end
      end
      for (int i = 0; i < NS; i++) begin
         if (ok && ts == i) begin
            if (in_cfg_op == 1'b0) begin
               m_alloc[i] = 1; m_mask[i] = in_cfg_mask; m_arr[i] = '0; m_gen[i] = '0; m_rel[i] = 0;
            end else begin
               m_alloc[i] = 0; m_mask[i] = '0; m_arr[i] = '0;
            end
         end else if (m_rel[i]) begin
            m_rel[i] = 0; m_arr[i] = newarr[i];
         end else if (m_alloc[i] && ((m_arr[i] | newarr[i]) == m_mask[i])) begin
            m_rel[i] = 1; m_gen[i] = m_gen[i] + 4'd1; m_arr[i] = '0;
         end else begin
            m_arr[i] = m_arr[i] | newarr[i];
         end
      end
      exp_done = in_cfg_valid;
      exp_ok   = ok;
      exp_release = '0;
      for (int i = 0; i < NS; i++) begin
         if (m_rel[i]) exp_release = exp_release | m_mask[i];
         exp_busy[i] = m_alloc[i];
         exp_gen[i*4 +: 4] = m_gen[i];
      end
      if (err) exp_error = 1'b1;
      else if (in_error_clear) exp_error = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      in_cfg_valid = 0; in_arrive = '0; in_error_clear = 0;
   endtask

   task automatic cmd(input logic op, input int slot, input logic [3:0] mask);
      in_cfg_valid = 1; in_cfg_op = op; in_cfg_slot = slot[1:0]; in_cfg_mask = mask;
   endtask

   task automatic arrive(input int core, input int slot);
      in_arrive[core] = 1'b1;
      in_arrive_slot[core*2 +: 2] = slot[1:0];
   endtask

   task automatic test_reset();
      reset_n = 0; in_cfg_valid = 0; in_cfg_op = 0; in_cfg_slot = '0; in_cfg_mask = '0;
      in_arrive = '0; in_arrive_slot = '0; in_error_clear = 0;
      model_reset();
      #1;
      n_checks++; if (out_release !== 4'b0) begin n_fail++; $display("FAIL reset_release: got %b expected 0000", out_release); end
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      n_checks++; if (out_cfg_done !== exp_done || out_cfg_ok !== exp_ok) begin n_fail++; $display("FAIL reset_cfg: got done=%b ok=%b expected 0 0", out_cfg_done, out_cfg_ok); end
      n_checks++; if (out_slot_busy !== exp_busy) begin n_fail++; $display("FAIL reset_busy: got %b expected %b", out_slot_busy, exp_busy); end
      n_checks++; if (out_generation !== exp_gen) begin n_fail++; $display("FAIL reset_gen: got %h expected %h", out_generation, exp_gen); end
      n_checks++; if (out_error !== exp_error) begin n_fail++; $display("FAIL reset_error: got %b expected %b", out_error, exp_error); end
      n_checks++; if (dbg_slots !== '0) begin n_fail++; $display("FAIL reset_dbg: got %h expected 0", dbg_slots); end
   endtask

   task automatic test_alloc();
      cmd(1'b0, 1, 4'b0111); tick();
      n_checks++; if (out_cfg_done !== exp_done) begin n_fail++; $display("FAIL alloc_done: got %b expected %b", out_cfg_done, exp_done); end
      n_checks++; if (out_cfg_ok !== exp_ok) begin n_fail++; $display("FAIL alloc_ok: got %b expected %b", out_cfg_ok, exp_ok); end
      n_checks++; if (out_slot_busy !== exp_busy) begin n_fail++; $display("FAIL alloc_busy: got %b expected %b", out_slot_busy, exp_busy); end
      tick();
      n_checks++; if (out_cfg_done !== exp_done) begin n_fail++; $display("FAIL alloc_done_pulse: got %b expected %b", out_cfg_done, exp_done); end
   endtask

   task automatic test_release();
      arrive(0, 1); arrive(2, 1); tick();
      n_checks++; if (out_release !== exp_release) begin n_fail++; $display("FAIL rel_partial: got %b expected %b", out_release, exp_release); end
      tick(); tick();
      arrive(1, 1); tick();
      n_checks++; if (out_release !== exp_release) begin n_fail++; $display("FAIL rel_final: got %b expected %b", out_release, exp_release); end
      n_checks++; if (out_generation !== exp_gen) begin n_fail++; $display("FAIL rel_gen: got %h expected %h", out_generation, exp_gen); end
      n_checks++; if (out_error !== exp_error) begin n_fail++; $display("FAIL rel_error: got %b expected %b", out_error, exp_error); end
      tick();
      n_checks++; if (out_release !== exp_release) begin n_fail++; $display("FAIL rel_one_cycle: got %b expected %b", out_release, exp_release); end
   endtask

   task automatic test_error();
      arrive(3, 1); tick();
      n_checks++; if (out_error !== exp_error) begin n_fail++; $display("FAIL err_nonpart: got %b expected %b", out_error, exp_error); end
      arrive(0, 1); tick();
      arrive(0, 1); tick();
      n_checks++; if (out_release !== exp_release) begin n_fail++; $display("FAIL err_dup_norel: got %b expected %b", out_release, exp_release); end
      tick();
      n_checks++; if (out_error !== exp_error) begin n_fail++; $display("FAIL err_sticky: got %b expected %b", out_error, exp_error); end
      in_error_clear = 1; arrive(3, 1); tick();
      n_checks++; if (out_error !== exp_error) begin n_fail++; $display("FAIL err_set_wins: got %b expected %b", out_error, exp_error); end
      in_error_clear = 1; tick();
      n_checks++; if (out_error !== exp_error) begin n_fail++; $display("FAIL err_clear: got %b expected %b", out_error, exp_error); end
      arrive(1, 1); arrive(2, 1); tick();
      n_checks++; if (out_release !== exp_release) begin n_fail++; $display("FAIL err_then_rel: got %b expected %b", out_release, exp_release); end
      n_checks++; if (out_generation !== exp_gen) begin n_fail++; $display("FAIL err_then_gen: got %h expected %h", out_generation, exp_gen); end
      tick();
   endtask

   task automatic test_dual_release();
      cmd(1'b0, 0, 4'b0011); tick();
      n_checks++; if (out_cfg_ok !== exp_ok) begin n_fail++; $display("FAIL dual_alloc0: got %b expected %b", out_cfg_ok, exp_ok); end
      cmd(1'b0, 2, 4'b1100); tick();
      n_checks++; if (out_cfg_ok !== exp_ok) begin n_fail++; $display("FAIL dual_alloc2: got %b expected %b", out_cfg_ok, exp_ok); end
      arrive(0, 0); arrive(2, 2); tick();
      arrive(1, 0); arrive(3, 2); tick();
      n_checks++; if (out_release !== exp_release) begin n_fail++; $display("FAIL dual_rel: got %b expected %b", out_release, exp_release); end
      n_checks++; if (out_generation !== exp_gen) begin n_fail++; $display("FAIL dual_gen: got %h expected %h", out_generation, exp_gen); end
      tick();
      n_checks++; if (out_release !== exp_release) begin n_fail++; $display("FAIL dual_rel_end: got %b expected %b", out_release, exp_release); end
   endtask

   task automatic test_cfg_reject();
      cmd(1'b0, 3, 4'b0000); tick();
      n_checks++; if (out_cfg_ok !== exp_ok || out_cfg_done !== exp_done) begin n_fail++; $display("FAIL rej_zero_mask: got ok=%b done=%b expected %b %b", out_cfg_ok, out_cfg_done, exp_ok, exp_done); end
      cmd(1'b0, 1, 4'b0001); tick();
      n_checks++; if (out_cfg_ok !== exp_ok) begin n_fail++; $display("FAIL rej_busy_alloc: got %b expected %b", out_cfg_ok, exp_ok); end
      arrive(0, 1); tick();
      cmd(1'b1, 1, 4'b0000); tick();
      n_checks++; if (out_cfg_ok !== exp_ok || out_slot_busy !== exp_busy) begin n_fail++; $display("FAIL rej_pending_free: got ok=%b busy=%b expected %b %b", out_cfg_ok, out_slot_busy, exp_ok, exp_busy); end
      arrive(1, 1); arrive(2, 1); tick();
      cmd(1'b1, 1, 4'b0000); tick();
      n_checks++; if (out_cfg_ok !== exp_ok) begin n_fail++; $display("FAIL rej_release_free: got %b expected %b", out_cfg_ok, exp_ok); end
      cmd(1'b1, 1, 4'b0000); tick();
      n_checks++; if (out_cfg_ok !== exp_ok || out_slot_busy !== exp_busy) begin n_fail++; $display("FAIL free_ok: got ok=%b busy=%b expected %b %b", out_cfg_ok, out_slot_busy, exp_ok, exp_busy); end
      cmd(1'b0, 1, 4'b0111); tick();
      cmd(1'b1, 1, 4'b0000); arrive(0, 1); tick();
      n_checks++; if (out_cfg_ok !== exp_ok || out_error !== exp_error) begin n_fail++; $display("FAIL free_with_arrival: got ok=%b err=%b expected %b %b", out_cfg_ok, out_error, exp_ok, exp_error); end
      in_error_clear = 1; tick();
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         if ($urandom_range(0, 3) == 0)
            cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, NS-1)), 4'($urandom_range(0, 15)));
         for (int c = 0; c < NC; c++)
            if ($urandom_range(0, 2) == 0) arrive(c, int'($urandom_range(0, NS-1)));
         if ($urandom_range(0, 7) == 0) in_error_clear = 1;
         tick();
         n_checks++;
         if (out_release !== exp_release || out_cfg_done !== exp_done || out_cfg_ok !== exp_ok ||
             out_slot_busy !== exp_busy || out_generation !== exp_gen || out_error !== exp_error) begin
            n_fail++;
            $display("FAIL random cyc %0d: got rel=%b done=%b ok=%b busy=%b gen=%h err=%b expected %b %b %b %b %h %b",
                     cyc, out_release, out_cfg_done, out_cfg_ok, out_slot_busy, out_generation, out_error,
                     exp_release, exp_done, exp_ok, exp_busy, exp_gen, exp_error);
         end
      end
   endtask

   task automatic test_reset_mid();
      reset_n = 0; model_reset();
      @(posedge clk); #1 reset_n = 1;
      cmd(1'b0, 0, 4'b0001); tick();
      cmd(1'b0, 1, 4'b0111); tick();
      arrive(3, 1); tick();
      arrive(0, 1); arrive(1, 1); arrive(0, 0); tick();
      n_checks++; if (out_release !== exp_release || out_error !== exp_error) begin n_fail++; $display("FAIL mid_pre: got rel=%b err=%b expected %b %b", out_release, out_error, exp_release, exp_error); end
      #2 reset_n = 0;
      #1;
      n_checks++;
      if (out_release !== 4'b0 || out_cfg_done !== 1'b0 || out_cfg_ok !== 1'b0 || out_slot_busy !== 4'b0 ||
          out_generation !== 16'h0 || out_error !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_async: got rel=%b done=%b ok=%b busy=%b gen=%h err=%b expected all 0",
                  out_release, out_cfg_done, out_cfg_ok, out_slot_busy, out_generation, out_error);
      end
      model_reset();
      @(posedge clk); #1 reset_n = 1;
      arrive(2, 1); tick();
      n_checks++; if (out_error !== exp_error || out_release !== exp_release) begin n_fail++; $display("FAIL mid_after: got err=%b rel=%b expected %b %b", out_error, out_release, exp_error, exp_release); end
      tick();
      n_checks++; if (out_release !== exp_release || out_slot_busy !== exp_busy) begin n_fail++; $display("FAIL mid_norel: got rel=%b busy=%b expected %b %b", out_release, out_slot_busy, exp_release, exp_busy); end
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_release();
      test_error();
      test_dual_release();
      test_cfg_reject();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
